// File: rtl/neuron_pkg.sv
// Shared widths, FSM encoding and sign-magnitude / saturating-add helpers for the neuron.
package neuron_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned WEIGHT_W = 16;
    localparam int unsigned MAG_W    = WEIGHT_W - 1;
    localparam int unsigned PROD_W   = MAG_W + SAMPLE_W;
    localparam int unsigned ACC_W    = 22;
    localparam int unsigned OUT_W    = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DIFF  = 3'd2,
        LUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // |P-N| with its sign, handed from the difference stage to the LUT stage
    typedef struct packed {
        logic             sign;
        logic [ACC_W-1:0] mag;
    } diff_t;

    function automatic logic w_sign(input logic [WEIGHT_W-1:0] w);
        return w[WEIGHT_W-1];
    endfunction

    function automatic logic [MAG_W-1:0] w_mag(input logic [WEIGHT_W-1:0] w);
        return w[MAG_W-1:0];
    endfunction

    // Add with clamp at all-ones; once at the clamp the sum stays there
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [SAMPLE_W-1:0] prod);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W + 1)'(prod);
        if (sum[ACC_W] || (acc == {ACC_W{1'b1}})) begin
            return {ACC_W{1'b1}};
        end
        return sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/neuron_mult.sv
// Shared unsigned multiplier: weight magnitude times sample, full-width product.
module neuron_mult #(
    parameter int unsigned A_W = 15,
    parameter int unsigned B_W = 16
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] prod_c
);

    assign prod_c = (A_W + B_W)'(a) * (A_W + B_W)'(b);

endmodule

// File: rtl/neuron_sigmoid_lut.sv
// Sigmoid approximation: 0.5 plus/minus (suma/16), clamped just inside [0,1).
module neuron_sigmoid_lut
    import neuron_pkg::*;
(
    input  logic [ACC_W-1:0] suma,
    input  logic             sign,
    output logic [OUT_W-1:0] prob_c
);

    localparam int unsigned HALF = 1 << (OUT_W - 1);

    logic [ACC_W-1:0] scaled;
    logic [OUT_W-2:0] delta;

    // Scale the difference, clamp to half range, then offset around 0.5
    always_comb begin
        scaled = suma >> 4;
        delta  = (scaled > ACC_W'(HALF - 1)) ? {(OUT_W - 1){1'b1}} : (OUT_W - 1)'(scaled);
        prob_c = sign ? (OUT_W'(HALF) - OUT_W'(delta)) : (OUT_W'(HALF) + OUT_W'(delta));
    end

endmodule

// File: rtl/neuron_weight_store.sv
// Register file of sign-magnitude weights: async clear, one write port, one combinational read port.
module neuron_weight_store
    import neuron_pkg::*;
#(
    parameter int unsigned N_INPUTS = 60,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [WEIGHT_W-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [WEIGHT_W-1:0] rdata_c
);

    logic [WEIGHT_W-1:0] mem [N_INPUTS];

    // Weight storage; reset clears every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_INPUTS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/neuron_seq_mac.sv
// Time-multiplexed neuron: one sample per beat through a shared multiplier, split P/N sums, sigmoid output.
module neuron_seq_mac
    import neuron_pkg::*;
#(
    parameter  int unsigned N_INPUTS = 60,
    localparam int unsigned ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w_we,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [WEIGHT_W-1:0] w_data,
    input  logic                start,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sign
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cnt;
    logic [ACC_W-1:0]    acc_p, acc_n;
    diff_t               diff_q;
    logic                beat_c, last_beat_c, clr_acc_c, wr_en_c;
    logic [WEIGHT_W-1:0] weight_c;
    logic [PROD_W-1:0]   prod_full_c;
    logic [SAMPLE_W-1:0] prod_c;
    logic [OUT_W-1:0]    prob_c;

    assign beat_c      = in_valid && in_ready;
    assign last_beat_c = (cnt == ADDR_W'(N_INPUTS - 1));
    assign prod_c      = SAMPLE_W'(prod_full_c >> MAG_W);

    neuron_weight_store #(
        .N_INPUTS (N_INPUTS),
        .ADDR_W   (ADDR_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en_c),
        .waddr   (w_addr),
        .wdata   (w_data),
        .raddr   (cnt),
        .rdata_c (weight_c)
    );

    neuron_mult #(
        .A_W (MAG_W),
        .B_W (SAMPLE_W)
    ) u_mult (
        .a      (w_mag(weight_c)),
        .b      (in_data),
        .prod_c (prod_full_c)
    );

    neuron_sigmoid_lut u_lut (
        .suma   (diff_q.mag),
        .sign   (diff_q.sign),
        .prob_c (prob_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, accumulator clear and weight-write qualification
    always_comb begin
        state_nx  = state;
        clr_acc_c = 1'b0;
        wr_en_c   = 1'b0;
        unique case (state)
            IDLE: begin
                wr_en_c = w_we && (32'(w_addr) < N_INPUTS);
                if (start) begin
                    state_nx  = ACCUM;
                    clr_acc_c = 1'b1;
                end
            end
            ACCUM:   if (beat_c && last_beat_c) state_nx = DIFF;
            DIFF:    state_nx = LUT;
            LUT:     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: beat counter, P/N sums, difference stage and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc_p     <= '0;
            acc_n     <= '0;
            diff_q    <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sign  <= 1'b0;
        end else begin
            busy     <= (state_nx != IDLE);
            in_ready <= (state_nx == ACCUM);
            if (clr_acc_c) begin
                cnt   <= '0;
                acc_p <= '0;
                acc_n <= '0;
            end else if (beat_c) begin
                cnt <= cnt + ADDR_W'(1);
                if (w_sign(weight_c)) begin
                    acc_n <= sat_add(acc_n, prod_c);
                end else begin
                    acc_p <= sat_add(acc_p, prod_c);
                end
            end
            if (state == DIFF) begin
                diff_q.sign <= !(acc_p > acc_n);
                diff_q.mag  <= (acc_p > acc_n) ? (acc_p - acc_n) : (acc_n - acc_p);
            end
            if (state == LUT) begin
                out_data  <= prob_c;
                out_sign  <= diff_q.sign;
                out_valid <= 1'b1;
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Directed bench: a 4-input instance for function/handshake/reset and an 80-input one for saturation.
module tb_neuron_seq_mac;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-input instance
    logic        w_we, start, busy, in_valid, in_ready, out_valid, out_ready, out_sign;
    logic [1:0]  w_addr;
    logic [15:0] w_data, in_data, out_data;

    // 80-input instance
    logic        s_w_we, s_start, s_busy, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sign;
    logic [6:0]  s_w_addr;
    logic [15:0] s_w_data, s_in_data, s_out_data;

    int n_checks = 0;
    int n_errors = 0;

    neuron_seq_mac #(.N_INPUTS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sign  (out_sign)
    );

    neuron_seq_mac #(.N_INPUTS(80)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_we      (s_w_we),
        .w_addr    (s_w_addr),
        .w_data    (s_w_data),
        .start     (s_start),
        .busy      (s_busy),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_sign  (s_out_sign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_w(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = a;
        w_data = d;
        @(negedge clk);
        w_we   = 1'b0;
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    // Feed 4 beats (optionally with gaps / a write attempt), then check latency, result and handshake
    task automatic feed(input string tag, input logic [15:0] s [4], input bit toggle,
                        input bit wr_accum, input int hold,
                        input logic [15:0] exp_d, input logic exp_s);
        int k = 0;
        int g = 0;
        int lat = 0;
        bit acc;
        while (k < 4 && g < 40) begin
            in_valid = toggle ? (g % 2 == 0) : 1'b1;
            in_data  = in_valid ? s[k] : 16'hFFFF;
            if (wr_accum && g == 0) begin
                w_we   = 1'b1;
                w_addr = 2'd0;
                w_data = 16'h7FFF;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            w_we = 1'b0;
            if (acc) k++;
            g++;
        end
        in_valid = 1'b0;
        check({tag, ".beats"}, 32'(k), 32'd4);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd2);
        check({tag, ".out_data"}, 32'(out_data), 32'(exp_d));
        check({tag, ".out_sign"}, 32'(out_sign), 32'(exp_s));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_data"}, 32'(out_data), 32'(exp_d));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, ".start_in_done_ignored"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] s_basic [4];
        logic [15:0] s_equal [4];
        int k;
        int g;
        bit acc;
        s_basic = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
        s_equal = '{16'h8000, 16'h8000, 16'h0000, 16'h0000};

        w_we = 0; w_addr = 0; w_data = 0; start = 0; in_valid = 0; in_data = 0; out_ready = 0;
        s_w_we = 0; s_w_addr = 0; s_w_data = 0; s_start = 0; s_in_valid = 0; s_in_data = 0; s_out_ready = 0;

        // Reset values
        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data", 32'(out_data), 32'd0);
        check("rst.out_sign", 32'(out_sign), 32'd0);
        check("rst.sat_busy", 32'(s_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: P=0x1000, N=0x800 -> mag 0x800, sign 0 -> 0x8000 + 0x80
        write_w(2'd0, 16'h4000);
        write_w(2'd1, 16'h4000);
        write_w(2'd2, 16'hC000);
        write_w(2'd3, 16'h0000);
        do_start("basic");
        feed("basic", s_basic, 1'b0, 1'b0, 0, 16'h8080, 1'b0);

        // Handshake: gapped beats, result held while out_ready low
        do_start("hshk");
        feed("hshk", s_basic, 1'b1, 1'b0, 5, 16'h8080, 1'b0);

        // Write attempted during ACCUM must be dropped; rerun gives the same result
        do_start("wprot1");
        feed("wprot1", s_basic, 1'b0, 1'b1, 0, 16'h8080, 1'b0);
        do_start("wprot2");
        feed("wprot2", s_basic, 1'b0, 1'b0, 0, 16'h8080, 1'b0);

        // Equal sums, last weight written in the same cycle as start: mag 0, sign 1 -> 0x8000
        write_w(2'd0, 16'h2000);
        write_w(2'd2, 16'h0000);
        write_w(2'd3, 16'h0000);
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = 2'd1;
        w_data = 16'hA000;
        start  = 1'b1;
        @(negedge clk);
        w_we  = 1'b0;
        start = 1'b0;
        check("equal.busy", 32'(busy), 32'd1);
        feed("equal", s_equal, 1'b0, 1'b0, 0, 16'h8000, 1'b1);

        // Saturation: 80 x 0xFFFD into N exceeds 0x3FFFFF -> clamp, output 0x0001, sign 1
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            s_w_we   = 1'b1;
            s_w_addr = 7'(i);
            s_w_data = 16'hFFFF;
        end
        @(negedge clk);
        s_w_we  = 1'b0;
        s_start = 1'b1;
        @(negedge clk);
        s_start    = 1'b0;
        s_in_valid = 1'b1;
        s_in_data  = 16'hFFFF;
        k = 0;
        g = 0;
        while (k < 80 && g < 200) begin
            acc = s_in_valid && s_in_ready;
            @(negedge clk);
            if (acc) k++;
            g++;
        end
        s_in_valid = 1'b0;
        check("sat.beats", 32'(k), 32'd80);
        g = 0;
        while (!s_out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("sat.latency", 32'(g), 32'd2);
        check("sat.out_data", 32'(s_out_data), 32'h0001);
        check("sat.out_sign", 32'(s_out_sign), 32'd1);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        check("sat.idle", 32'(s_busy), 32'd0);

        // Reset after two beats: outputs drop at once, weights cleared afterwards
        write_w(2'd0, 16'h4000);
        write_w(2'd1, 16'h4000);
        write_w(2'd2, 16'hC000);
        do_start("rstmid");
        in_valid = 1'b1;
        in_data  = 16'h1000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.in_ready", 32'(in_ready), 32'd0);
        check("rstmid.out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_start("after_rst");
        feed("after_rst", s_basic, 1'b0, 1'b0, 0, 16'h8000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
